sort_triples: RTL and testbench

SORT_TRIPLES -- requirements
Module: sort_triples

---
 rtl/sort_triples_if.sv | 27 ++
 rtl/sort_triples.sv | 109 ++++++++++
 tb/tb_sort_triples.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_triples_if.sv
// Bus bundle for the triple sorter: start request, unsorted input array,
// working/sorted output array and the busy/done status flags.
interface sort_triples_if #(
   parameter int STRING_LEN = 8
);
   logic                                start;
   logic [STRING_LEN-1:0][2:0][7:0]     data_in;
   logic [STRING_LEN-1:0][2:0][7:0]     data_out;
   logic                                busy;
   logic                                done;

   modport master (
      output start,
      output data_in,
      input  data_out,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data_in,
      output data_out,
      output busy,
      output done
   );
endinterface

// File: rtl/sort_triples.sv
// Odd-even transposition sorter for STRING_LEN triples (rank0, rank1, index).
// One transposition phase per clock; exits early after two consecutive
// swap-free phases, otherwise after phase STRING_LEN-1.
module sort_triples #(
   parameter int STRING_LEN = 8
) (
   input logic           clk,
   input logic           rst,
   sort_triples_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                          state;
   state_t                          state_next;
   logic [STRING_LEN-1:0][2:0][7:0] arr;
   logic [STRING_LEN-1:0][2:0][7:0] arr_phase;
   logic [7:0]                      phase_cnt;
   logic                            no_swap_prev;
   logic                            any_swap;
   logic                            last_phase;
   logic                            early_exit;

   // Full 24-bit key: rank0 most significant, then rank1, then index.
   function automatic logic [23:0] key_of(input logic [2:0][7:0] t);
      return {t[0], t[1], t[2]};
   endfunction

   // One transposition phase: disjoint pairs compared on the current array,
   // selected by the phase parity, all swapped in parallel.
   always_comb begin
      arr_phase = arr;
      any_swap  = 1'b0;
      for (int j = 0; j < STRING_LEN - 1; j++) begin
         if (((j % 2) == 1) == phase_cnt[0]) begin
            if (key_of(arr[j]) > key_of(arr[j+1])) begin
               arr_phase[j]   = arr[j+1];
               arr_phase[j+1] = arr[j];
               any_swap       = 1'b1;
            end
         end
      end
   end

   // A two-element array is fully sorted by its single even phase.
   assign last_phase = (phase_cnt == 8'(STRING_LEN - 1)) || (STRING_LEN == 2);
   assign early_exit = !any_swap && no_swap_prev;

   // Next-state decode: capture on start, sort until finished, pulse done.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = SORT;
            end
         end
         SORT: begin
            if (last_phase || early_exit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Working array, phase counter and swap history; captured in IDLE, updated
   // once per phase in SORT, held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arr          <= '0;
         phase_cnt    <= 8'd0;
         no_swap_prev <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            arr          <= bus.data_in;
            phase_cnt    <= 8'd0;
            no_swap_prev <= 1'b0;
         end else if (state == SORT) begin
            arr          <= arr_phase;
            phase_cnt    <= phase_cnt + 8'd1;
            no_swap_prev <= !any_swap;
         end
      end
   end

   assign bus.data_out = arr;
   assign bus.busy     = (state == SORT);
   assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_sort_triples.sv
// Scoreboard bench for sort_triples with STRING_LEN = 8: directed vectors
// with hand-derived results, reset/abort/ignored-start/held-start cases and
// a batch of random vectors checked against a reference insertion sort.
module tb_sort_triples;

   typedef logic [7:0][2:0][7:0] arr_t;

   typedef struct {
      arr_t data;
      int   start_cyc;
      int   lat_min;
      int   lat_max;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   exp_t  exp_q[$];
   string name_q[$];

   exp_t  mon_e;
   string mon_nm;
   int    mon_lat;

   sort_triples_if #(.STRING_LEN(8)) bus ();

   sort_triples #(.STRING_LEN(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure start-to-done latency.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] key_tb(input logic [2:0][7:0] t);
      return {t[0], t[1], t[2]};
   endfunction

   // Reference sort (insertion sort on the full key).
   function automatic arr_t sort_model(input arr_t a);
      arr_t             r;
      logic [2:0][7:0]  t;
      r = a;
      for (int i = 1; i < 8; i++) begin
         int j;
         j = i;
         while (j > 0 && key_tb(r[j-1]) > key_tb(r[j])) begin
            t      = r[j];
            r[j]   = r[j-1];
            r[j-1] = t;
            j--;
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string nm, input logic [191:0] act, input logic [191:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic checkRange(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
      end
   endtask

   // Drive one start pulse; returns #1 after the edge that samples it.
   task automatic issueStart(input arr_t din);
      @(negedge clk);
      bus.data_in = din;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic applyStimulus(input arr_t din, input arr_t expv, input int lmin, input int lmax,
                                input string nm);
      exp_t e;
      issueStart(din);
      e.data      = expv;
      e.start_cyc = cyc;
      e.lat_min   = lmin;
      e.lat_max   = lmax;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Bounded wait for done, then confirm it lasts a single cycle.
   task automatic waitDone(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < 20);
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout actual=no_done required=done_within_20", nm);
      end else begin
         @(negedge clk);
         checkOutput({nm, "_done_width"}, {191'd0, bus.done}, 192'd0);
      end
   endtask

   // Monitor: on every done pulse pop the oldest expectation and compare.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            checkOutput({mon_nm, "_data"}, bus.data_out, mon_e.data);
            if (mon_e.lat_min >= 0) begin
               mon_lat = cyc - mon_e.start_cyc;
               checkRange({mon_nm, "_latency"}, mon_lat, mon_e.lat_min, mon_e.lat_max);
            end
         end
      end
   end

   initial begin
      arr_t din;
      arr_t expv;
      arr_t rev_in;
      arr_t rev_exp;
      arr_t sorted_in;
      arr_t tie_in;
      arr_t tie_exp;
      int   r1_tab[8];
      int   ix_tab[8];
      int   pulses;
      int   d1;
      int   d2;

      checks = 0;
      errors = 0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.data_in = '0;

      for (int i = 0; i < 8; i++) begin
         rev_in[i][0]    = 8'(7 - i);
         rev_in[i][1]    = 8'd0;
         rev_in[i][2]    = 8'(i);
         rev_exp[i][0]   = 8'(i);
         rev_exp[i][1]   = 8'd0;
         rev_exp[i][2]   = 8'(7 - i);
         sorted_in[i][0] = 8'(i);
         sorted_in[i][1] = 8'd0;
         sorted_in[i][2] = 8'(i);
         tie_in[i][0]    = 8'd3;
         tie_in[i][1]    = (i % 2 == 0) ? 8'd5 : 8'd1;
         tie_in[i][2]    = 8'(i);
      end
      r1_tab = '{1, 1, 1, 1, 5, 5, 5, 5};
      ix_tab = '{1, 3, 5, 7, 0, 2, 4, 6};
      for (int i = 0; i < 8; i++) begin
         tie_exp[i][0] = 8'd3;
         tie_exp[i][1] = 8'(r1_tab[i]);
         tie_exp[i][2] = 8'(ix_tab[i]);
      end

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b0;
      #1;
      checkOutput("reset_data_out", bus.data_out, 192'd0);
      checkOutput("reset_busy", {191'd0, bus.busy}, 192'd0);
      checkOutput("reset_done", {191'd0, bus.done}, 192'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("idle_after_reset_busy", {191'd0, bus.busy}, 192'd0);

      // Reverse-ordered input: worst case, full eight phases.
      applyStimulus(rev_in, rev_exp, 8, 8, "reverse");
      checkOutput("reverse_busy", {191'd0, bus.busy}, 192'd1);
      waitDone("reverse");

      // Already sorted: two swap-free phases then done.
      applyStimulus(sorted_in, sorted_in, 2, 2, "presorted");
      waitDone("presorted");
      repeat (3) @(negedge clk);
      checkOutput("hold_idle_data", bus.data_out, sorted_in);
      checkOutput("hold_idle_busy", {191'd0, bus.busy}, 192'd0);

      // Ties on rank0 resolved by rank1 then index.
      applyStimulus(tie_in, tie_exp, 2, 8, "tie");
      waitDone("tie");

      // Extremes 0x00/0xFF must order as unsigned.
      for (int i = 0; i < 8; i++) begin
         din[i][0] = (i % 2 == 0) ? 8'hFF : 8'h00;
         din[i][1] = 8'd0;
         din[i][2] = 8'(i);
      end
      for (int i = 0; i < 4; i++) begin
         expv[i][0]   = 8'h00;
         expv[i][1]   = 8'd0;
         expv[i][2]   = 8'(2 * i + 1);
         expv[i+4][0] = 8'hFF;
         expv[i+4][1] = 8'd0;
         expv[i+4][2] = 8'(2 * i);
      end
      applyStimulus(din, expv, 2, 8, "unsigned");
      waitDone("unsigned");

      // Reset in the middle of a sort aborts it without a done pulse.
      issueStart(rev_in);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort_data_out", bus.data_out, 192'd0);
      checkOutput("abort_busy", {191'd0, bus.busy}, 192'd0);
      checkOutput("abort_done", {191'd0, bus.done}, 192'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      checkOutput("abort_no_done", 192'(pulses), 192'd0);
      checkOutput("abort_needs_start", {191'd0, bus.busy}, 192'd0);
      applyStimulus(tie_in, tie_exp, 2, 8, "after_abort");
      waitDone("after_abort");

      // New data and start during SORT are ignored.
      applyStimulus(rev_in, rev_exp, 8, 8, "ignore_start");
      @(negedge clk);
      @(negedge clk);
      bus.data_in = '0;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      checkOutput("ignore_start_pulses", 192'(pulses), 192'd1);

      // Start held high: captures repeat with an IDLE cycle between pulses.
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         mon_e.data      = sorted_in;
         mon_e.start_cyc = 0;
         mon_e.lat_min   = -1;
         mon_e.lat_max   = -1;
         exp_q.push_back(mon_e);
         name_q.push_back("held");
      end
      bus.data_in = sorted_in;
      bus.start   = 1'b1;
      pulses = 0;
      d1 = 0;
      d2 = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            pulses++;
            if (pulses == 1) d1 = cyc;
            if (pulses == 2) d2 = cyc;
         end
      end
      bus.start = 1'b0;
      checkOutput("held_pulses", 192'(pulses), 192'd2);
      checkOutput("held_gap", 192'(d2 - d1), 192'd4);
      waitDone("held3");

      // Random vectors with narrow rank ranges to force ties.
      for (int run = 0; run < 1000; run++) begin
         for (int i = 0; i < 8; i++) begin
            din[i][0] = 8'($urandom_range(0, 3));
            din[i][1] = 8'($urandom_range(0, 3));
            din[i][2] = 8'($urandom_range(0, 255));
         end
         if (run % 4 == 0) begin
            for (int i = 0; i < 8; i++) din[i][0] = 8'($urandom_range(0, 255));
         end
         applyStimulus(din, sort_model(din), 2, 8, "random");
         waitDone("random");
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 192'(exp_q.size()), 192'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
